alu_issue_unit: RTL

ALU_ISSUE_UNIT -- requirements
Module: alu_issue_unit

---
 rtl/alu_issue_pkg.sv | 29 ++
 rtl/alu_issue_wdog.sv | 28 ++
 rtl/alu_issue_unit.sv | 122 ++++++++++++
 3 files changed

// File: rtl/alu_issue_pkg.sv
// Shared types and constants for the ALU issue unit: state encoding,
// instruction-form codes, watchdog limit and the three-halfword instruction layout.
package alu_issue_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IMM1  = 2'd1,
    IMM2  = 2'd2,
    ISSUE = 2'd3
  } state_t;

  localparam logic [3:0] FORM_REG = 4'b0100;
  localparam logic [3:0] FORM_IMM = 4'b1100;

  localparam int WDOG_LIMIT = 16;
  localparam int WDOG_W     = $clog2(WDOG_LIMIT + 1);

  // Halfwords in fetch order: lo arrives first, hi last.
  typedef struct packed {
    logic [15:0] hi;
    logic [15:0] mid;
    logic [15:0] lo;
  } inst_t;

  function automatic logic is_form(input logic [15:0] hw, input logic [3:0] form);
    return hw[3:0] == form;
  endfunction

endpackage

// File: rtl/alu_issue_wdog.sv
// ISSUE-state watchdog, present only with ALU_ISSUE_WDOG_EN; expire is combinational
// and fires in the ISSUE cycle whose done-low increment would reach WDOG_LIMIT.
`ifdef ALU_ISSUE_WDOG_EN
module alu_issue_wdog
  import alu_issue_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic in_issue,
  input  logic done,
  output logic expire
);

  logic [WDOG_W-1:0] count;

  // Held at zero outside ISSUE, so every ISSUE entry starts from a clean count.
  always_ff @(posedge clk) begin
    if (rst || !in_issue) begin
      count <= '0;
    end else if (!done) begin
      count <= count + WDOG_W'(1);
    end
  end

  assign expire = in_issue && !done && (count == WDOG_W'(WDOG_LIMIT - 1));

endmodule
`endif

// File: rtl/alu_issue_unit.sv
// Assembles 1- or 3-halfword instructions and issues them to the ALU; en/inst registered
// one edge after the last halfword; hw_ready drops in ISSUE and on flush. Option: ALU_ISSUE_WDOG_EN.
module alu_issue_unit
  import alu_issue_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        hw_valid,
  input  logic [15:0] hw_data,
  output logic        hw_ready,
  input  logic        flush,
  output logic        en,
  output logic [47:0] inst,
  input  logic        done,
  output logic        busy,
  output logic        illegal,
  output logic [15:0] issue_count,
  output logic        timeout_err
);

  state_t state, state_nx;
  inst_t  inst_q, inst_nx;
  logic   illegal_nx;
  logic   xfer;
  logic   complete;
  logic   expire;

  assign hw_ready = (state != ISSUE) && !flush;
  assign xfer     = hw_valid && hw_ready;
  assign complete = (state == ISSUE) && done;
  assign inst     = inst_q;

`ifdef ALU_ISSUE_WDOG_EN
  alu_issue_wdog u_wdog (
    .clk      (clk),
    .rst      (rst),
    .in_issue (state == ISSUE),
    .done     (done),
    .expire   (expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= expire;
    end
  end
`else
  assign expire      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_nx   = state;
    inst_nx    = inst_q;
    illegal_nx = 1'b0;
    case (state)
      IDLE: begin
        if (flush) begin
          inst_nx = '0;
        end else if (xfer) begin
          if (is_form(hw_data, FORM_REG)) begin
            inst_nx  = inst_t'({32'h0, hw_data});
            state_nx = ISSUE;
          end else if (is_form(hw_data, FORM_IMM)) begin
            inst_nx.lo = hw_data;
            state_nx   = IMM1;
          end else begin
            illegal_nx = 1'b1;
          end
        end
      end
      IMM1: begin
        if (flush) begin
          inst_nx  = '0;
          state_nx = IDLE;
        end else if (xfer) begin
          inst_nx.mid = hw_data;
          state_nx    = IMM2;
        end
      end
      IMM2: begin
        if (flush) begin
          inst_nx  = '0;
          state_nx = IDLE;
        end else if (xfer) begin
          inst_nx.hi = hw_data;
          state_nx   = ISSUE;
        end
      end
      ISSUE: begin
        // done takes priority over a watchdog expiry in the same cycle; flush is ignored here.
        if (done || expire) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      inst_q      <= '0;
      en          <= 1'b0;
      busy        <= 1'b0;
      illegal     <= 1'b0;
      issue_count <= 16'h0000;
    end else begin
      state   <= state_nx;
      inst_q  <= inst_nx;
      en      <= (state_nx == ISSUE);
      busy    <= (state_nx != IDLE);
      illegal <= illegal_nx;
      if (complete) begin
        issue_count <= issue_count + 16'd1;
      end
    end
  end

endmodule
